uart_receiver: RTL and testbench

//  Asynchronous serial receiver, 8N1 (optional even parity), LSB first, idle-high line.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_receiver.sv | 162 ++++++++++++++++
 tb/tb_uart_receiver.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the baud accumulator increment
// used by both the receiver and the transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } uart_rx_state_t;

   // Rounded fixed-point increment: baud*oversample*2^width / clk_freq
   function automatic logic [63:0] baud_inc(input logic [63:0] clk_freq,
                                            input logic [63:0] baud,
                                            input logic [63:0] oversample,
                                            input logic [63:0] width);
      logic [63:0] num;
      num = (baud * oversample) << width;
      return (num + (clk_freq >> 1)) / clk_freq;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional accumulator producing one-cycle ticks at OVERSAMPLE x baud.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 65000000,
   parameter int unsigned BAUD_RATE  = 230400,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned ACC_WIDTH  = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);

   localparam logic [63:0] INC64 = baud_inc(64'(CLK_FREQ), 64'(BAUD_RATE),
                                            64'(OVERSAMPLE), 64'(ACC_WIDTH));
   localparam logic [ACC_WIDTH:0] INC = INC64[ACC_WIDTH:0];

   logic [ACC_WIDTH:0] acc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else begin
         acc <= {1'b0, acc[ACC_WIDTH-1:0]} + INC;
      end
   end

   assign tick = acc[ACC_WIDTH];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, mid-bit sampling with OVERSAMPLE x baud ticks.
// Define UART_RX_PARITY_EN for 9-bit frames with even parity checking.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 65000000,
   parameter int unsigned BAUD_RATE  = 230400,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned ACC_WIDTH  = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_error,
   output logic       rx_parity_error,
   output logic       rx_busy
);

   localparam int unsigned CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

   logic rx_meta, rx_s, rx_prev;
   logic tick, baud_clear;

   uart_rx_state_t state, state_n;
   logic [CW-1:0]  sample_cnt, sample_cnt_n;
   logic [2:0]     bitpos, bitpos_n;
   logic [7:0]     shift, shift_n;
   logic           par_err, par_err_n;
   logic [7:0]     rx_data_n;
   logic           valid_n, ferr_n, perr_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   uart_baud_gen #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD_RATE),
      .OVERSAMPLE (OVERSAMPLE),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_baud_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (baud_clear),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= RX_IDLE;
         sample_cnt      <= '0;
         bitpos          <= '0;
         shift           <= '0;
         par_err         <= 1'b0;
         rx_data         <= '0;
         rx_valid        <= 1'b0;
         rx_frame_error  <= 1'b0;
         rx_parity_error <= 1'b0;
      end else begin
         state           <= state_n;
         sample_cnt      <= sample_cnt_n;
         bitpos          <= bitpos_n;
         shift           <= shift_n;
         par_err         <= par_err_n;
         rx_data         <= rx_data_n;
         rx_valid        <= valid_n;
         rx_frame_error  <= ferr_n;
         rx_parity_error <= perr_n;
      end
   end

   always_comb begin
      state_n      = state;
      sample_cnt_n = sample_cnt;
      bitpos_n     = bitpos;
      shift_n      = shift;
      par_err_n    = par_err;
      rx_data_n    = rx_data;
      valid_n      = 1'b0;
      ferr_n       = 1'b0;
      perr_n       = 1'b0;
      baud_clear   = 1'b0;

      // Outside IDLE the sample counter free-runs on ticks; only START rebases it
      if (state != RX_IDLE && tick) begin
         sample_cnt_n = sample_cnt + 1'b1;
      end

      case (state)
         RX_IDLE: begin
            if (rx_prev && !rx_s) begin
               state_n      = RX_START;
               sample_cnt_n = '0;
               baud_clear   = 1'b1;
            end
         end
         RX_START: begin
            if (tick && sample_cnt == MID) begin
               if (!rx_s) begin
                  state_n      = RX_DATA;
                  sample_cnt_n = '0;
                  bitpos_n     = '0;
                  par_err_n    = 1'b0;
               end else begin
                  state_n = RX_IDLE;
               end
            end
         end
         RX_DATA: begin
            if (tick && sample_cnt == LAST) begin
               shift_n = {rx_s, shift[7:1]};
               if (bitpos == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_n = RX_PARITY;
`else
                  state_n = RX_STOP;
`endif
               end else begin
                  bitpos_n = bitpos + 3'd1;
               end
            end
         end
         RX_PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (tick && sample_cnt == LAST) begin
               par_err_n = rx_s ^ (^shift);
               state_n   = RX_STOP;
            end
`else
            state_n = RX_IDLE;
`endif
         end
         RX_STOP: begin
            if (tick && sample_cnt == LAST) begin
               state_n = RX_IDLE;
               if (rx_s && !par_err) begin
                  rx_data_n = shift;
                  valid_n   = 1'b1;
               end
               ferr_n = !rx_s;
               perr_n = par_err;
            end
         end
         default: state_n = RX_IDLE;
      endcase
   end

   assign rx_busy = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 3.6864 MHz / 115200 baud (32 clk per bit).
module tb_uart_receiver;

   localparam int BIT = 32;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       uart_rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, rx_frame_error, rx_parity_error, rx_busy;

   int n_cmp = 0;
   int n_err = 0;
   int cycle = 0;
   int start_cycle = 0;
   logic [7:0] last_good = 8'h00;
   logic [10:0] sb[$];   // {valid, frame_err, parity_err, rx_data}

   uart_receiver #(
      .CLK_FREQ   (3686400),
      .BAUD_RATE  (115200),
      .OVERSAMPLE (16),
      .ACC_WIDTH  (16)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .uart_rx         (uart_rx),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .rx_frame_error  (rx_frame_error),
      .rx_parity_error (rx_parity_error),
      .rx_busy         (rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && (rx_valid || rx_frame_error || rx_parity_error)) begin
         if (sb.size() == 0) begin
            check("spurious_strobe", {29'd0, rx_valid, rx_frame_error, rx_parity_error}, 32'd0);
         end else begin
            logic [10:0] e;
            e = sb.pop_front();
            check("strobes", {29'd0, rx_valid, rx_frame_error, rx_parity_error}, {29'd0, e[10:8]});
            check("rx_data", {24'd0, rx_data}, {24'd0, e[7:0]});
            if (e[10] && e[7:0] == 8'hA5)
               check("latency_ok", 32'((cycle - start_cycle) >= 296 && (cycle - start_cycle) <= 316), 32'd1);
         end
      end
   end

   task automatic drive_bit(input logic b);
      uart_rx = b;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
      logic bad;
      bad = !stop_bit;
`ifdef UART_RX_PARITY_EN
      bad = bad || par_flip;
`endif
      if (!bad) begin
         sb.push_back({3'b100, d});
         last_good = d;
      end else begin
         sb.push_back({1'b0, !stop_bit, par_flip, last_good});
      end
      start_cycle = cycle;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^d) ^ par_flip);
`endif
      drive_bit(stop_bit);
      uart_rx = 1'b1;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
      check(tag, 32'(sb.size()), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_data"},  {24'd0, rx_data}, 32'd0);
      check({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
      check({tag, "_ferr"},  {31'd0, rx_frame_error}, 32'd0);
      check({tag, "_perr"},  {31'd0, rx_parity_error}, 32'd0);
      check({tag, "_busy"},  {31'd0, rx_busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1. reset
      repeat (4) @(negedge clk);
      check_reset_vals("rst_held");
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      check_reset_vals("rst_rel");

      // 2. single byte
      send_frame(8'hA5, 1'b1, 1'b0);
      drain("drain_a5");
      repeat (8) @(negedge clk);

      // 3. back-to-back
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      drain("drain_b2b");
      repeat (8) @(negedge clk);

      // 4. framing error
      send_frame(8'h3C, 1'b0, 1'b0);
      drain("drain_ferr");
      repeat (8) @(negedge clk);
      check("data_kept", {24'd0, rx_data}, 32'h0000_00FF);

      // 5. glitch
      uart_rx = 1'b0;
      repeat (5) @(negedge clk);
      check("glitch_busy", {31'd0, rx_busy}, 32'd1);
      repeat (5) @(negedge clk);
      uart_rx = 1'b1;
      repeat (20) @(negedge clk);
      check("glitch_idle", {31'd0, rx_busy}, 32'd0);

      // 6. reset mid-frame
      uart_rx = 1'b0;
      repeat (BIT) @(negedge clk);
      uart_rx = 1'b1;
      repeat (BIT) @(negedge clk);
      uart_rx = 1'b0;
      repeat (BIT / 2) @(negedge clk);
      check("mid_busy", {31'd0, rx_busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      last_good = 8'h00;
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      send_frame(8'h81, 1'b1, 1'b0);
      drain("drain_81");
`ifdef UART_RX_PARITY_EN
      repeat (8) @(negedge clk);
      send_frame(8'h81, 1'b1, 1'b1);
      drain("drain_perr");
`endif
      repeat (40) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
